rs_deinterleaver: RTL and testbench

- Receive-side inverse of the transmit byte interleaver. It sits between the RX descrambler and the RS decoder.
- Accepts one interleaved frame of DEPTH RS codewords as a byte stream. It reassembles the frame into DEPTH consecutive codewords of N bytes each.
- Uses a ping-pong pair of frame buffers, so one frame can be written while the previous one is drained.
- Supports backpressure on both sides.

---
 rtl/rs_deinterleaver_if.sv | 16 +
 rtl/rs_deinterleaver.sv | 104 ++++++++++
 tb/tb_rs_deinterleaver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/rs_deinterleaver_if.sv
// rs_deinterleaver_if: byte-stream bus; slave = deinterleaver (s_axis in, m_axis out, err pulses out), master = its environment
interface rs_deinterleaver_if;
  logic s_axis_valid, s_axis_ready, s_axis_sop, s_axis_last;
  logic [7:0] s_axis_data;
  logic m_axis_valid, m_axis_ready, m_axis_sop, m_axis_last;
  logic [7:0] m_axis_data;
  logic err_sync, err_len;
  modport slave (
    input s_axis_valid, s_axis_data, s_axis_sop, s_axis_last, m_axis_ready,
    output s_axis_ready, m_axis_valid, m_axis_data, m_axis_sop, m_axis_last, err_sync, err_len
  );
  modport master (
    output s_axis_valid, s_axis_data, s_axis_sop, s_axis_last, m_axis_ready,
    input s_axis_ready, m_axis_valid, m_axis_data, m_axis_sop, m_axis_last, err_sync, err_len
  );
endinterface

// File: rtl/rs_deinterleaver.sv
// rs_deinterleaver: ping-pong frame deinterleaver; ports clk, rst_n (sync active-low), bus (slave: s_axis byte stream in, m_axis codeword stream out, err_sync/err_len pulses)
module rs_deinterleaver #(
  parameter int N = 255,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst_n,
  rs_deinterleaver_if.slave bus
);
  localparam int FB = N * DEPTH;
  localparam int AW = $clog2(FB + 1);
  localparam int JW = $clog2(N + 1);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, DRAINING = 2'd3;
  logic [7:0] mem_q [2][FB];
  logic [1:0] st_q [2], st_d [2];
  logic wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, wa, ra;
  logic [JW-1:0] j_q, j_d;
  logic [CW-1:0] cw_q, cw_d;
  logic [7:0] d_q [2];
  logic [1:0] sop_q, lst_q, fe_q, bk_q, cnt_q;
  logic wp_q, rp_q, rdy_q, err_sync_q, err_len_q;
  logic acc, resync, at_end, pop, issue, jw, frame_end;
  assign acc = bus.s_axis_valid && rdy_q;
  assign resync = bus.s_axis_sop && wr_ptr_q != '0;
  assign wa = resync ? '0 : wr_ptr_q;
  assign at_end = wa == AW'(FB - 1);
  assign pop = cnt_q != 2'd0 && bus.m_axis_ready;
  assign issue = (st_q[rd_sel_q] == FULL || st_q[rd_sel_q] == DRAINING) && (cnt_q != 2'd2 || pop);
  assign jw = j_q == JW'(N - 1);
  assign frame_end = jw && cw_q == CW'(DEPTH - 1);
  assign ra = AW'(32'(j_q) * DEPTH + 32'(cw_q));
  always_comb begin
    st_d = st_q;
    wr_sel_d = wr_sel_q;
    wr_ptr_d = wr_ptr_q;
    rd_sel_d = rd_sel_q;
    j_d = j_q;
    cw_d = cw_q;
    if (acc) begin
      st_d[wr_sel_q] = at_end ? FULL : FILLING;
      wr_ptr_d = at_end ? '0 : wa + AW'(1);
      wr_sel_d = wr_sel_q ^ at_end;
    end
    if (issue) begin
      st_d[rd_sel_q] = DRAINING;
      j_d = jw ? '0 : j_q + JW'(1);
      cw_d = frame_end ? '0 : cw_q + CW'(jw);
      rd_sel_d = rd_sel_q ^ frame_end;
    end
    if (pop && fe_q[rp_q]) st_d[bk_q[rp_q]] = EMPTY;
  end
  always_ff @(posedge clk)
    if (acc) mem_q[wr_sel_q][wa] <= bus.s_axis_data;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q <= '{EMPTY, EMPTY};
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      wr_ptr_q <= '0;
      j_q <= '0;
      cw_q <= '0;
      d_q <= '{default: '0};
      sop_q <= '0;
      lst_q <= '0;
      fe_q <= '0;
      bk_q <= '0;
      cnt_q <= '0;
      wp_q <= 1'b0;
      rp_q <= 1'b0;
      rdy_q <= 1'b0;
      err_sync_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      st_q <= st_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      wr_ptr_q <= wr_ptr_d;
      j_q <= j_d;
      cw_q <= cw_d;
      cnt_q <= cnt_q + 2'(issue) - 2'(pop);
      wp_q <= wp_q ^ issue;
      rp_q <= rp_q ^ pop;
      rdy_q <= st_d[wr_sel_d] == EMPTY || st_d[wr_sel_d] == FILLING;
      err_sync_q <= acc && resync;
      err_len_q <= acc && (bus.s_axis_last != at_end);
      if (issue) begin
        d_q[wp_q] <= mem_q[rd_sel_q][ra];
        sop_q[wp_q] <= j_q == '0;
        lst_q[wp_q] <= jw;
        fe_q[wp_q] <= frame_end;
        bk_q[wp_q] <= rd_sel_q;
      end
    end
  end
  assign bus.s_axis_ready = rdy_q;
  assign bus.m_axis_valid = cnt_q != 2'd0;
  assign bus.m_axis_data = d_q[rp_q];
  assign bus.m_axis_sop = sop_q[rp_q];
  assign bus.m_axis_last = lst_q[rp_q];
  assign bus.err_sync = err_sync_q;
  assign bus.err_len = err_len_q;
endmodule

// File: tb/tb_rs_deinterleaver.sv
// tb_rs_deinterleaver: directed self-checking bench against a frame-level reference model
module tb_rs_deinterleaver;
  localparam int N = 255, DEPTH = 4, FB = N * DEPTH;
  typedef struct { logic [7:0] d; logic sop, lst, fe; int at; } exp_t;
  typedef struct { logic [7:0] d; logic sop, lst; } byte_t;
  logic clk = 1'b0, rst_n = 1'b0;
  rs_deinterleaver_if bus();
  rs_deinterleaver #(.N(N), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, smp = 0;
  int pos = 0, fin = 0, fout = 0, es_cnt = 0, el_cnt = 0;
  byte_t in_q[$], out_log[$];
  exp_t q[$];
  int out_smp[$], done_smp[$];
  logic [7:0] frm [FB];
  logic in_hs = 0, exp_es = 0, exp_el = 0, rst_prev = 0, stall = 0, rs;
  logic [9:0] held = '0;
  bit vrnd = 0, rrnd = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (sample %0d)", name, act, exp, smp);
    end
  endtask
  always @(negedge clk) begin
    smp++;
    in_hs = 0;
    if (!rst_prev) begin
      chk("reset_outs", {bus.s_axis_ready, bus.m_axis_valid, bus.m_axis_data, bus.m_axis_sop,
                         bus.m_axis_last, bus.err_sync, bus.err_len}, 0);
      q.delete();
      pos = 0;
      fin = 0;
      fout = 0;
      exp_es = 0;
      exp_el = 0;
      stall = 0;
    end else begin
      chk("s_ready", bus.s_axis_ready, 32'((fin - fout) < 2));
      chk("err_sync", bus.err_sync, exp_es);
      chk("err_len", bus.err_len, exp_el);
      es_cnt += int'(bus.err_sync);
      el_cnt += int'(bus.err_len);
      chk("m_valid", bus.m_axis_valid, 32'(q.size() > 0 && smp >= q[0].at));
      if (stall)
        chk("stall_hold", {bus.m_axis_valid, bus.m_axis_sop, bus.m_axis_last, bus.m_axis_data}, {1'b1, held});
      exp_es = 0;
      exp_el = 0;
      if (rst_n) begin
        if (bus.m_axis_valid && bus.m_axis_ready && q.size() > 0) begin
          chk("out_byte", {bus.m_axis_sop, bus.m_axis_last, bus.m_axis_data}, {q[0].sop, q[0].lst, q[0].d});
          out_log.push_back('{bus.m_axis_data, bus.m_axis_sop, bus.m_axis_last});
          out_smp.push_back(smp);
          if (q[0].fe) fout++;
          void'(q.pop_front());
        end
        if (bus.s_axis_valid && bus.s_axis_ready) begin
          in_hs = 1;
          rs = bus.s_axis_sop && pos != 0;
          if (rs) pos = 0;
          exp_es = rs;
          exp_el = bus.s_axis_last != (pos == FB - 1);
          frm[pos] = bus.s_axis_data;
          pos++;
          if (pos == FB) begin
            pos = 0;
            fin++;
            done_smp.push_back(smp);
            for (int c = 0; c < DEPTH; c++)
              for (int j = 0; j < N; j++)
                q.push_back('{frm[j * DEPTH + c], j == 0, j == N - 1, c == DEPTH - 1 && j == N - 1, smp + 2});
          end
        end
      end
      stall = rst_n && bus.m_axis_valid && !bus.m_axis_ready;
      held = {bus.m_axis_sop, bus.m_axis_last, bus.m_axis_data};
    end
    rst_prev = rst_n;
  end
  task automatic step();
    @(posedge clk);
    #1;
    if (in_hs) void'(in_q.pop_front());
    bus.s_axis_valid = in_q.size() > 0 && (!vrnd || $urandom_range(1, 0) == 1);
    if (in_q.size() > 0) begin
      bus.s_axis_data = in_q[0].d;
      bus.s_axis_sop = in_q[0].sop;
      bus.s_axis_last = in_q[0].lst;
    end
    bus.m_axis_ready = !rrnd || $urandom_range(1, 0) == 1;
  endtask
  task automatic push_frame(int seed, int extra_last);
    for (int p = 0; p < FB; p++) in_q.push_back('{8'((p + seed) % 256), p == 0, p == FB - 1 || p == extra_last});
  endtask
  task automatic run(int lim);
    int n = 0;
    while ((in_q.size() > 0 || q.size() > 0) && n < lim) begin
      step();
      n++;
    end
    chk("run_done", 32'(n < lim), 1);
    repeat (4) step();
  endtask
  task automatic clear_logs();
    out_log.delete();
    out_smp.delete();
    done_smp.delete();
    es_cnt = 0;
    el_cnt = 0;
  endtask
  initial begin
    int idx[6] = '{0, 1, 2, 3, 255, 1019};
    logic [7:0] val[6] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h01, 8'hFB};
    int n;
    bus.s_axis_valid = 0;
    bus.s_axis_data = 0;
    bus.s_axis_sop = 0;
    bus.s_axis_last = 0;
    bus.m_axis_ready = 1;
    repeat (3) step();
    rst_n = 1;
    step();
    chk("ready_after_reset", bus.s_axis_ready, 1);
    clear_logs();
    push_frame(0, -1);
    run(3000);
    chk("basic_count", out_log.size(), FB);
    for (int i = 0; i < 6; i++) chk($sformatf("basic_out%0d", idx[i]), out_log[idx[i]].d, val[i]);
    for (int c = 0; c < DEPTH; c++) begin
      chk($sformatf("basic_sop%0d", c * N), out_log[c * N].sop, 1);
      chk($sformatf("basic_last%0d", c * N + N - 1), out_log[c * N + N - 1].lst, 1);
    end
    chk("basic_sop1", out_log[1].sop, 0);
    chk("basic_latency", out_smp[0] - done_smp[0], 2);
    clear_logs();
    for (int f = 1; f <= 3; f++) push_frame(f, -1);
    run(8000);
    chk("b2b_count", out_log.size(), 3 * FB);
    chk("b2b_f1_first", out_log[FB].d, 8'h02);
    chk("b2b_f2_out255", out_log[2 * FB + 255].d, 8'h04);
    chk("b2b_f2_last", out_log[3 * FB - 1].d, 8'hFE);
    clear_logs();
    vrnd = 1;
    rrnd = 1;
    for (int f = 0; f < 4; f++) push_frame(8'h50 + f, -1);
    run(30000);
    vrnd = 0;
    rrnd = 0;
    chk("bp_count", out_log.size(), 4 * FB);
    chk("bp_f0_out1", out_log[1].d, 8'h54);
    chk("bp_f3_out255", out_log[3 * FB + 255].d, 8'h54);
    clear_logs();
    for (int p = 0; p < 500; p++) in_q.push_back('{8'(p), p == 0, 1'b0});
    push_frame(8'h10, -1);
    run(4000);
    chk("sop_err_sync_pulses", es_cnt, 1);
    chk("sop_err_len_pulses", el_cnt, 0);
    chk("sop_count", out_log.size(), FB);
    chk("sop_out0", out_log[0].d, 8'h10);
    chk("sop_out1", out_log[1].d, 8'h14);
    chk("sop_out255", out_log[255].d, 8'h11);
    clear_logs();
    push_frame(8'h20, 100);
    run(3000);
    chk("len_err_len_pulses", el_cnt, 1);
    chk("len_err_sync_pulses", es_cnt, 0);
    chk("len_count", out_log.size(), FB);
    chk("len_out1019", out_log[FB - 1].d, 8'h1B);
    clear_logs();
    push_frame(8'h30, -1);
    n = 0;
    while (out_log.size() < 300 && n < 3000) begin
      step();
      n++;
    end
    chk("rst_reach300", 32'(out_log.size() >= 300), 1);
    rst_n = 0;
    in_q.delete();
    bus.s_axis_valid = 0;
    step();
    rst_n = 1;
    repeat (3) step();
    chk("rst_ready_after", bus.s_axis_ready, 1);
    chk("rst_no_valid", bus.m_axis_valid, 0);
    clear_logs();
    push_frame(8'h40, -1);
    run(3000);
    chk("rst_new_count", out_log.size(), FB);
    chk("rst_new_out0", out_log[0].d, 8'h40);
    chk("rst_new_out1019", out_log[FB - 1].d, 8'h3B);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
